// File: rtl/max_scan_pkg.sv
// Shared types and default sizing for the max_scan block.
package max_scan_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/max_scan_if.sv
// Request/operand/result bundle for max_scan; out_idx exists only with MAX_SCAN_INDEX_EN.
interface max_scan_if #(
  parameter int unsigned WIDTH = max_scan_pkg::WIDTH_DEF,
  parameter int unsigned CNT_W = max_scan_pkg::CNT_W_DEF
);

  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic             busy;
`ifdef MAX_SCAN_INDEX_EN
  logic [CNT_W-1:0] out_idx;
`endif

  modport master (
    output start, len, in_valid, in_data, out_ready,
`ifdef MAX_SCAN_INDEX_EN
    input  out_idx,
`endif
    input  in_ready, out_valid, out_max, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
`ifdef MAX_SCAN_INDEX_EN
    output out_idx,
`endif
    output in_ready, out_valid, out_max, busy
  );

endinterface

// File: rtl/max_cmp.sv
// Combinational unsigned max: y = (a > b) ? a : b, so ties return b.
module max_cmp #(
  parameter int unsigned WIDTH = max_scan_pkg::WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = (a > b) ? a : b;

endmodule

// File: rtl/max_scan.sv
// Streaming maximum over a length-prefixed burst of unsigned operands.
// Define MAX_SCAN_INDEX_EN to also report the position of the first maximum on out_idx.
module max_scan
  import max_scan_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  max_scan_if.slave   bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             first_q, first_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
`ifdef MAX_SCAN_INDEX_EN
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] idx_q, idx_d;
`endif

  logic [WIDTH-1:0] cmp_y;
  logic             accept;
  logic             take;

  // in_data sits on 'a' so that an equal operand loses and the earlier value is kept.
  max_cmp #(.WIDTH(WIDTH)) u_max_cmp (
    .a (bus.in_data),
    .b (acc_q),
    .y (cmp_y)
  );

  assign accept = in_ready_q && bus.in_valid;
  // cmp_y differs from acc_q exactly when in_data is strictly larger.
  assign take   = first_q || (cmp_y != acc_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    first_d     = first_q;
`ifdef MAX_SCAN_INDEX_EN
    pos_d       = pos_q;
    idx_d       = idx_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          first_d = 1'b1;
          cnt_d   = bus.len;
`ifdef MAX_SCAN_INDEX_EN
          pos_d   = '0;
          idx_d   = '0;
`endif
          state_d = (bus.len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          first_d = 1'b0;
          if (take) begin
            acc_d = first_q ? bus.in_data : cmp_y;
`ifdef MAX_SCAN_INDEX_EN
            idx_d = pos_q;
`endif
          end
`ifdef MAX_SCAN_INDEX_EN
          pos_d = pos_q + CNT_W'(1);
`endif
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags follow the next state so they are registered alongside it.
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      first_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MAX_SCAN_INDEX_EN
      pos_q       <= '0;
      idx_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef MAX_SCAN_INDEX_EN
      pos_q       <= pos_d;
      idx_q       <= idx_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_max   = acc_q;
  assign bus.busy      = busy_q;
`ifdef MAX_SCAN_INDEX_EN
  assign bus.out_idx   = idx_q;
`endif

endmodule

// File: tb/tb_max_scan.sv
// Self-checking bench for max_scan: vector table plus scoreboard of expected results.
module tb_max_scan;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 8;
  localparam int unsigned NV = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  max_scan_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  max_scan #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0]  mx;
    logic [CW-1:0] idx;
  } exp_t;

  typedef struct {
    int unsigned   len;
    logic [W-1:0]  ops [8];
    logic [W-1:0]  mx;
    logic [CW-1:0] idx;
    bit            gaps;
    int unsigned   hold;
    bit            poke;
  } vec_t;

  int unsigned  checks;
  int unsigned  failures;
  exp_t         sb_q [$];
  logic [W-1:0] ops_q [$];
  vec_t         vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: first occurrence of the unsigned maximum.
  function automatic exp_t model(input int unsigned len);
    exp_t e;
    e.mx  = '0;
    e.idx = '0;
    for (int i = 0; i < int'(len); i++) begin
      if (i == 0 || ops_q[i] > e.mx) begin
        e.mx  = ops_q[i];
        e.idx = CW'(i);
      end
    end
    return e;
  endfunction

  task automatic run_scan(input int unsigned len, input exp_t e, input bit gaps,
                          input int unsigned hold, input bit poke);
    exp_t got;
    bit   acc;
    bit   phase;
    bit   done;
    int   guard;
    bus.start = 1'b1;
    bus.len   = CW'(len);
    sb_q.push_back(e);
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    phase = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      done  = 1'b0;
      guard = 0;
      while (!done) begin
        bus.in_valid = gaps ? phase : 1'b1;
        phase        = ~phase;
        bus.in_data  = ops_q[i];
        if (poke && i == 1) begin
          bus.start = 1'b1;
          bus.len   = CW'(1);
        end
        acc = bus.in_ready && bus.in_valid;
        tick();
        bus.start = 1'b0;
        if (acc) done = 1'b1;
        guard++;
        if (!done && guard > 20) begin
          chk("accept_timeout", 32'd0, 32'd1);
          bus.in_valid = 1'b0;
          return;
        end
      end
    end
    bus.in_valid = 1'b0;
    chk("out_valid_latency", 32'(bus.out_valid), 32'd1);
    for (int h = 0; h < int'(hold); h++) begin
      logic [W-1:0] m0;
      m0 = bus.out_max;
      tick();
      chk("hold_out_max", 32'(bus.out_max), 32'(m0));
      chk("hold_busy", 32'(bus.busy), 32'd1);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    if (poke) begin
      bus.start = 1'b1;
      bus.len   = CW'(3);
    end
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      chk("out_max", 32'(bus.out_max), 32'(got.mx));
`ifdef MAX_SCAN_INDEX_EN
      chk("out_idx", 32'(bus.out_idx), 32'(got.idx));
`endif
    end
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    exp_t e;
    checks   = 0;
    failures = 0;

    vec[0] = '{len: 2, ops: '{16'd10, 16'd20, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
               mx: 16'd20, idx: 8'd1, gaps: 1'b0, hold: 0, poke: 1'b0};
    vec[1] = '{len: 2, ops: '{16'd40, 16'd30, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
               mx: 16'd40, idx: 8'd0, gaps: 1'b0, hold: 0, poke: 1'b0};
    vec[2] = '{len: 3, ops: '{16'd7, 16'd7, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
               mx: 16'd7, idx: 8'd0, gaps: 1'b0, hold: 0, poke: 1'b0};
    vec[3] = '{len: 0, ops: '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
               mx: 16'd0, idx: 8'd0, gaps: 1'b0, hold: 1, poke: 1'b0};
    vec[4] = '{len: 4, ops: '{16'd3, 16'd8, 16'd8, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0},
               mx: 16'd8, idx: 8'd1, gaps: 1'b1, hold: 5, poke: 1'b0};
    vec[5] = '{len: 5, ops: '{16'd5, 16'd4, 16'd9, 16'd9, 16'd1, 16'd0, 16'd0, 16'd0},
               mx: 16'd9, idx: 8'd2, gaps: 1'b0, hold: 2, poke: 1'b1};
    vec[6] = '{len: 1, ops: '{16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
               mx: 16'hFFFF, idx: 8'd0, gaps: 1'b0, hold: 0, poke: 1'b0};
    vec[7] = '{len: 3, ops: '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
               mx: 16'd0, idx: 8'd0, gaps: 1'b0, hold: 0, poke: 1'b0};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_max", 32'(bus.out_max), 32'd0);
`ifdef MAX_SCAN_INDEX_EN
    chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
`endif
    rst = 1'b0;
    tick();

    for (int v = 0; v < int'(NV); v++) begin
      ops_q.delete();
      for (int k = 0; k < int'(vec[v].len); k++) ops_q.push_back(vec[v].ops[k]);
      e.mx  = vec[v].mx;
      e.idx = vec[v].idx;
      run_scan(vec[v].len, e, vec[v].gaps, vec[v].hold, vec[v].poke);
    end

    // Maximum length with a planted peak that has a later tie.
    ops_q.delete();
    for (int k = 0; k < 255; k++) ops_q.push_back(W'($urandom_range(0, 16'hFFF0)));
    ops_q[200] = 16'hFFFE;
    ops_q[230] = 16'hFFFE;
    e = model(255);
    chk("model_peak", 32'(e.mx), 32'hFFFE);
    run_scan(255, e, 1'b0, 0, 1'b0);

    // Reset in the middle of a scan discards it.
    ops_q.delete();
    bus.start = 1'b1;
    bus.len   = CW'(4);
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd11;
    tick();
    bus.in_data  = 16'd22;
    tick();
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_out_max", 32'(bus.out_max), 32'd0);
`ifdef MAX_SCAN_INDEX_EN
    chk("abort_out_idx", 32'(bus.out_idx), 32'd0);
`endif
    tick();
    tick();
    chk("abort_no_valid", 32'(bus.out_valid), 32'd0);
    ops_q.push_back(16'd1);
    ops_q.push_back(16'd9);
    e.mx  = 16'd9;
    e.idx = 8'd1;
    run_scan(2, e, 1'b0, 0, 1'b0);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/max_scan.md
MAX_SCAN -- requirements
Module: max_scan

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter CNT_W, default 8, width of length/count/index fields.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
REQ-006 len  input  CNT_W  number of operands in the scan, unsigned; sampled with start.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 in_data  input  WIDTH  operand, unsigned.
REQ-010 out_valid  output  1  out_max holds the final result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_max  output  WIDTH  maximum of the scanned operands.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ACCUM and DONE.
REQ-015 IDLE->ACCUM on start with len!=0; IDLE->DONE on start with len==0, with out_max=0; start is ignored outside IDLE.
REQ-016 in_ready SHALL be 1 only in ACCUM; an operand is accepted when in_valid&&in_ready.
REQ-017 The first accepted operand SHALL load the accumulator unconditionally; each later operand replaces it only if in_data > accumulator (unsigned, strict), so on ties the earlier value is kept.
REQ-018 The comparison SHALL be performed by one shared combinational comparator instance (max_cmp) fed by the accumulator and in_data.
REQ-019 The remaining count SHALL decrement per accepted operand; acceptance of operand number len moves ACCUM->DONE on the same edge.
REQ-020 Latency: out_valid SHALL rise in the cycle immediately after the last operand is accepted.
REQ-021 In DONE, out_valid=1 and out_max SHALL stay stable until out_valid&&out_ready; the FSM then enters IDLE on that edge.
REQ-022 A start asserted in the same cycle as the DONE handshake SHALL be ignored; a new scan begins only from IDLE.
REQ-023 Gaps in in_valid SHALL stall the scan with no state change other than waiting.
REQ-024 len=2^CNT_W-1 SHALL be supported with no counter wrap.

Reset
REQ-025 On rst: state=IDLE, in_ready=0, out_valid=0, busy=0, out_max=0, count=0 (and out_idx=0 when present).
REQ-026 rst asserted mid-scan SHALL abort it; partial results are discarded, no out_valid follows.

Configuration
REQ-027 Macro MAX_SCAN_INDEX_EN: when defined, output port out_idx (CNT_W bits) SHALL give the 0-based position of the first occurrence of the maximum, valid with out_valid; len==0 gives out_idx=0.
REQ-028 Without MAX_SCAN_INDEX_EN, out_idx and its position counter SHALL not exist; all other behaviour is identical.

Structure
REQ-029 Shared package max_scan_pkg SHALL hold the FSM state enumeration (IDLE, ACCUM, DONE) and default WIDTH/CNT_W constants.
REQ-030 Sub-module max_cmp SHALL be the only comparator: inputs a, b (WIDTH), output y = (a>b) ? a : b, purely combinational.

Verification
REQ-031 start, len=2, operands 10,20 -> out_valid one cycle after second accept, out_max=20 (out_idx=1).
REQ-032 start, len=2, operands 40,30 -> out_max=40 (out_idx=0).
REQ-033 len=3, operands 7,7,5 -> out_max=7, out_idx=0 (tie keeps earlier); len=0 -> immediate DONE, out_max=0.
REQ-034 len=4, in_valid toggled every other cycle, out_ready held 0 for 5 cycles in DONE -> out_max stable, busy=1 throughout, IDLE after handshake.
REQ-035 rst asserted after 2 of 4 operands -> IDLE next cycle, all outputs 0; new scan 1,9 -> out_max=9.
REQ-036 start pulsed during ACCUM and during DONE handshake -> ignored, current scan result unchanged.
